// File: rtl/boot_pkg.sv
// Shared definitions for the streaming boot loader: FSM state encoding,
// frame-field sizes and a small state-classification helper.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        HOLD,
        RUN,
        ERROR
    } boot_state_e;

    // Frame layout: two little-endian length bytes, payload, one checksum byte.
    localparam int HDR_BYTES  = 2;
    localparam int CSUM_BYTES = 1;

    // States in which a frame is partially received and the idle timer runs.
    function automatic logic is_frame_state(input boot_state_e s);
        return (s == LEN_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Byte-to-word assembler: collects DATA_W/8 bytes little-endian (first byte
// lands in bits [7:0]) and presents the finished word with a one-cycle
// word_done strobe on the cycle after the final byte is accepted.
module boot_word_asm #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              word_last,
    output logic [DATA_W-1:0] word_data,
    output logic              word_done
);

    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]  byte_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_next;

    // New bytes enter at the top so the oldest byte ends up in bits [7:0].
    always_comb begin
        shift_next = shift_q >> 8;
        shift_next[DATA_W-1 -: 8] = byte_in;
    end

    assign word_last = byte_valid && (byte_cnt == CNT_W'(BPW - 1));

    // Shift accepted bytes, and latch the completed word for one write cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt  <= '0;
            shift_q   <= '0;
            word_data <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (byte_valid) begin
                shift_q <= shift_next;
                if (word_last) begin
                    byte_cnt  <= '0;
                    word_data <= shift_next;
                    word_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/boot_loader_stream.sv
// Streaming boot loader: receives a length-prefixed program image over a
// byte stream, writes it into instruction RAM, verifies an 8-bit additive
// checksum and then releases the CPU with a timed reset pulse.
module boot_loader_stream
    import boot_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int RST_HOLD = 4,
    parameter int TIMEOUT  = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              boot_skip,
    input  logic              reboot,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              booting,
    output logic              cpu_rst,
    output logic              boot_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    boot_state_e       state_q;
    boot_state_e       state_d;
    logic              armed_q;
    logic              reboot_q;
    logic [7:0]        len_lo_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   words_issued_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [7:0]        csum_q;
    logic [TO_W-1:0]   idle_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [15:0]       len_full;
    logic              accept;
    logic              timed_out;
    logic              word_last;
    logic              word_done;
    logic [DATA_W-1:0] word_data;

    assign len_full = {rx_data, len_lo_q};

    // Ready is held off for the first cycle after reset, and boot_skip in
    // LEN_LO takes priority over an incoming byte.
    assign rx_ready = armed_q && ((state_q == LEN_LO) ? !boot_skip : is_frame_state(state_q));
    assign accept   = rx_valid && rx_ready;

    assign timed_out = (TIMEOUT != 0) && is_frame_state(state_q) && !accept
                       && (idle_cnt_q == TO_W'(TIMEOUT - 1));

    boot_word_asm #(
        .DATA_W (DATA_W)
    ) u_word_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_valid (accept && (state_q == DATA)),
        .byte_in    (rx_data),
        .word_last  (word_last),
        .word_data  (word_data),
        .word_done  (word_done)
    );

    assign mem_we    = word_done;
    assign mem_wdata = word_data;
    assign mem_addr  = word_done ? words_loaded[ADDR_W-1:0] : last_addr_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and the state-derived status outputs.
    always_comb begin
        state_d  = state_q;
        booting  = 1'b1;
        cpu_rst  = 1'b1;
        boot_err = 1'b0;
        case (state_q)
            LEN_LO: begin
                if (boot_skip) begin
                    state_d = HOLD;
                end else if (accept) begin
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    if (32'(len_full) > 32'(DEPTH)) begin
                        state_d = ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end else if (timed_out) begin
                    state_d = ERROR;
                end
            end
            DATA: begin
                if (word_last && (words_issued_q == len_q - 1'b1)) begin
                    state_d = CSUM;
                end else if (timed_out) begin
                    state_d = ERROR;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? HOLD : ERROR;
                end else if (timed_out) begin
                    state_d = ERROR;
                end
            end
            HOLD: begin
                booting = 1'b0;
                if (hold_cnt_q == HOLD_W'(RST_HOLD - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                booting = 1'b0;
                cpu_rst = 1'b0;
                if (reboot && !reboot_q) begin
                    state_d = HOLD;
                end
            end
            ERROR: begin
                boot_err = 1'b1;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    // Frame bookkeeping: length capture, checksum, word counters and timers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q        <= 1'b0;
            reboot_q       <= 1'b0;
            len_lo_q       <= '0;
            len_q          <= '0;
            words_issued_q <= '0;
            words_loaded   <= '0;
            last_addr_q    <= '0;
            csum_q         <= '0;
            idle_cnt_q     <= '0;
            hold_cnt_q     <= '0;
        end else begin
            armed_q  <= 1'b1;
            reboot_q <= reboot;
            if (accept && (state_q == LEN_LO)) begin
                len_lo_q <= rx_data;
            end
            if (accept && (state_q == LEN_HI)) begin
                len_q <= len_full[ADDR_W:0];
            end
            if (accept && (state_q == DATA)) begin
                csum_q <= csum_q + rx_data;
            end
            if (word_last) begin
                words_issued_q <= words_issued_q + 1'b1;
            end
            if (word_done) begin
                words_loaded <= words_loaded + 1'b1;
                last_addr_q  <= words_loaded[ADDR_W-1:0];
            end
            if (!is_frame_state(state_q) || accept) begin
                idle_cnt_q <= '0;
            end else begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
            end
            if (state_q == HOLD) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end else begin
                hold_cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_boot_loader_stream.sv
// Self-checking bench for boot_loader_stream: directed frames, timing of the
// CPU reset pulse, error paths, and randomized frames checked against a
// queue-based frame model.
module tb_boot_loader_stream;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 10;
    localparam int RST_HOLD = 4;
    localparam int TIMEOUT  = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              boot_skip = 1'b0;
    logic              reboot = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              booting;
    logic              cpu_rst;
    logic              boot_err;
    logic [ADDR_W:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    int wr_base = 0;
    logic [DATA_W-1:0] tb_ram [0:(2**ADDR_W)-1];

    boot_loader_stream #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .RST_HOLD (RST_HOLD),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .boot_skip    (boot_skip),
        .reboot       (reboot),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .booting      (booting),
        .cpu_rst      (cpu_rst),
        .boot_err     (boot_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Behavioural RAM capturing every write the loader issues.
    always @(posedge clk) begin
        if (mem_we) begin
            tb_ram[mem_addr] <= mem_wdata;
            wr_total <= wr_total + 1;
        end
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        boot_skip = 1'b0;
        reboot = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_base = wr_total;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Called #1 after the edge that enters HOLD: reset stays high for
    // RST_HOLD cycles, then the CPU runs.
    task automatic expect_hold_then_run(input string tag);
        check({tag, "_hold_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_hold_booting"}, 32'(booting), 32'd0);
        for (int i = 1; i < RST_HOLD; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_hold%0d", tag, i), 32'(cpu_rst), 32'd1);
        end
        @(posedge clk);
        #1;
        check({tag, "_run_cpu_rst"}, 32'(cpu_rst), 32'd0);
        check({tag, "_run_booting"}, 32'(booting), 32'd0);
    endtask

    // Builds a frame from a word list, streams it with random idle gaps and
    // checks the outcome against the frame rules.
    task automatic run_frame(input logic [15:0] words[$], input bit bad_csum,
                             input int max_gap, input string tag);
        logic [7:0] frame[$];
        int sum;
        logic [7:0] csum;
        int n;
        n = words.size();
        sum = 0;
        frame.push_back(8'(n));
        frame.push_back(8'(n >> 8));
        foreach (words[i]) begin
            frame.push_back(words[i][7:0]);
            frame.push_back(words[i][15:8]);
            sum += int'(words[i][7:0]) + int'(words[i][15:8]);
        end
        csum = 8'(sum % 256);
        if (bad_csum) csum = csum ^ 8'($urandom_range(1, 255));
        frame.push_back(csum);
        foreach (frame[i]) begin
            if (i > 0 && max_gap > 0) repeat ($urandom_range(0, max_gap)) @(posedge clk);
            send_byte(frame[i]);
        end
        if (bad_csum) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_err"}, 32'(boot_err), 32'd1);
            check({tag, "_err_cpu_rst"}, 32'(cpu_rst), 32'd1);
            check({tag, "_err_booting"}, 32'(booting), 32'd1);
            check({tag, "_err_rx_ready"}, 32'(rx_ready), 32'd0);
        end else begin
            expect_hold_then_run(tag);
            check({tag, "_no_err"}, 32'(boot_err), 32'd0);
        end
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(n));
        check({tag, "_write_count"}, 32'(wr_total - wr_base), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ram%0d", tag, i), 32'(tb_ram[i]), 32'(words[i]));
        end
    endtask

    initial begin
        logic [15:0] words[$];

        // Reset values while rst_n is held low.
        #2;
        check("rst_booting", 32'(booting), 32'd1);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_boot_err", 32'(boot_err), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);

        // Directed two-word frame, then reboot while running.
        do_reset();
        check("lenlo_rx_ready", 32'(rx_ready), 32'd1);
        words = '{16'h1234, 16'h5678};
        run_frame(words, 1'b0, 0, "basic");
        @(negedge clk);
        reboot = 1'b1;
        @(posedge clk);
        #1;
        expect_hold_then_run("reboot");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reboot_held_run", 32'(cpu_rst), 32'd0);
        end
        reboot = 1'b0;
        check("reboot_words_loaded", 32'(words_loaded), 32'd2);
        check("reboot_write_count", 32'(wr_total - wr_base), 32'd2);

        // Directed bad checksum, error must persist.
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
        send_byte(8'hC5);
        check("badcsum_err", 32'(boot_err), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("badcsum_sticky_err", 32'(boot_err), 32'd1);
        check("badcsum_sticky_cpu_rst", 32'(cpu_rst), 32'd1);
        check("badcsum_sticky_booting", 32'(booting), 32'd1);
        check("badcsum_sticky_rx_ready", 32'(rx_ready), 32'd0);

        // Length one beyond DEPTH errors right after len_hi.
        do_reset();
        send_byte(8'h01); send_byte(8'h04);
        check("len_over_err", 32'(boot_err), 32'd1);
        check("len_over_mem_we", 32'(mem_we), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("len_over_writes", 32'(wr_total - wr_base), 32'd0);

        // Length exactly DEPTH is accepted.
        do_reset();
        send_byte(8'h00); send_byte(8'h04);
        check("len_max_no_err", 32'(boot_err), 32'd0);
        check("len_max_rx_ready", 32'(rx_ready), 32'd1);

        // Zero-length frame goes straight to checksum.
        do_reset();
        words = {};
        run_frame(words, 1'b0, 0, "empty");

        // Idle for TIMEOUT-1 cycles mid-load does not error.
        do_reset();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h34);
        repeat (TIMEOUT - 1) @(posedge clk);
        send_byte(8'h12);
        check("idle99_no_err", 32'(boot_err), 32'd0);
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h14);
        expect_hold_then_run("idle99");

        // Idle for TIMEOUT cycles mid-load errors on exactly that cycle.
        do_reset();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h34);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        check("timeout_before", 32'(boot_err), 32'd0);
        @(posedge clk);
        #1;
        check("timeout_at", 32'(boot_err), 32'd1);
        check("timeout_cpu_rst", 32'(cpu_rst), 32'd1);

        // boot_skip with a simultaneous byte: byte refused, straight to HOLD.
        do_reset();
        @(negedge clk);
        boot_skip = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'hAA;
        #1;
        check("skip_rx_ready", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
        boot_skip = 1'b0;
        rx_valid = 1'b0;
        expect_hold_then_run("skip");
        check("skip_words_loaded", 32'(words_loaded), 32'd0);
        check("skip_writes", 32'(wr_total - wr_base), 32'd0);

        // Randomized frames, some with corrupted checksums.
        for (int f = 0; f < 8; f++) begin
            int n;
            bit bad;
            n = $urandom_range(1, 12);
            bad = ($urandom_range(0, 3) == 0);
            words = {};
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            do_reset();
            run_frame(words, bad, 30, $sformatf("rnd%0d", f));
        end

        // Asynchronous abort in the middle of the payload.
        do_reset();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h78);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_booting", 32'(booting), 32'd1);
        check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        check("abort_boot_err", 32'(boot_err), 32'd0);
        check("abort_rx_ready", 32'(rx_ready), 32'd0);
        check("abort_mem_we", 32'(mem_we), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_wdata", 32'(mem_wdata), 32'd0);
        check("abort_words_loaded", 32'(words_loaded), 32'd0);
        check("abort_ram_kept", 32'(tb_ram[0]), 32'h1234);
        do_reset();
        check("post_abort_rx_ready", 32'(rx_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
